// File: rtl/spi_receive_multi.sv
// Multi-line SPI receiver (peripheral side) with valid/ready hand-off.
// All three SPI inputs are synchronized into clk_in before use; DCLK edges are
// detected by oversampling. Optional idle-DCLK timeout enabled by defining
// SPI_RX_TIMEOUT_EN; without it, partial words persist until CS rises.
module spi_receive_multi #(
    parameter int DATA_WIDTH     = 8,
    parameter int LINES          = 1,
    parameter int CPOL           = 0,
    parameter int CPHA           = 0,
    parameter int MSB_FIRST      = 1,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic [LINES-1:0]              chip_data_in,
    input  logic                          chip_clk_in,
    input  logic                          chip_sel_in,
    output logic [LINES*DATA_WIDTH-1:0]   data_out,
    output logic                          data_valid_out,
    input  logic                          data_ready_in,
    output logic                          overrun_out,
    output logic                          frame_err_out,
    output logic [15:0]                   word_count_out
);

    localparam int CntW = $clog2(DATA_WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);
    localparam bit CpolBit = (CPOL != 0);
    localparam bit SampleRise = (CPOL == CPHA);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    logic [SYNC_STAGES-1:0]             sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0]             cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0][LINES-1:0]  data_sync_q, data_sync_d;

    state_e                             state_q, state_d;
    logic                               sclk_prev_q, sclk_prev_d;
    logic [CntW-1:0]                    bit_cnt_q, bit_cnt_d;
    logic [LINES-1:0][DATA_WIDTH-1:0]   shift_q, shift_d, shift_next;
    logic [LINES-1:0][DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                               valid_q, valid_d;
    logic                               ovr_q, ovr_d;
    logic                               fe_q, fe_d;
    logic [15:0]                        wc_q, wc_d;

    logic                               sclk_s, cs_s;
    logic [LINES-1:0]                   data_s;
    logic                               sample_edge;
    logic                               tmo_fire;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    // Synchronizer shift chains
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], chip_clk_in};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], chip_sel_in};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], chip_data_in};
    end

    // A sample edge only counts while selected in SHIFT, so an edge that lands
    // together with CS deassertion is dropped.
    assign sample_edge = (state_q == StShift) && !cs_s &&
                         (SampleRise ? (sclk_s && !sclk_prev_q) : (!sclk_s && sclk_prev_q));

    // Per-line shift value for the current sample
    always_comb begin
        shift_next = shift_q;
        for (int l = 0; l < LINES; l++) begin
            if (MSB_FIRST != 0) begin
                shift_next[l] = {shift_q[l][DATA_WIDTH-2:0], data_s[l]};
            end else begin
                shift_next[l] = {data_s[l], shift_q[l][DATA_WIDTH-1:1]};
            end
        end
    end

`ifdef SPI_RX_TIMEOUT_EN
    localparam int TmoW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TmoW-1:0] tmo_q, tmo_d;

    // Idle-DCLK counter: runs only while a partial word is pending
    always_comb begin
        tmo_d    = '0;
        tmo_fire = 1'b0;
        if ((state_q == StShift) && !cs_s && (bit_cnt_q != '0) && !sample_edge) begin
            if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                tmo_fire = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // Timeout counter register
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
    assign tmo_fire       = 1'b0;
`endif

    // Receive FSM, output holding register and status pulses
    always_comb begin
        state_d     = state_q;
        sclk_prev_d = sclk_prev_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_out_d  = data_out_q;
        valid_d     = valid_q;
        ovr_d       = 1'b0;
        fe_d        = 1'b0;
        wc_d        = wc_q;

        if (valid_q && data_ready_in) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                // Holding CPOL here means SHIFT starts with the idle level as history
                sclk_prev_d = CpolBit;
                if (!cs_s) begin
                    state_d = StShift;
                    wc_d    = '0;
                end
            end
            StShift: begin
                sclk_prev_d = sclk_s;
                if (cs_s) begin
                    state_d = StIdle;
                    if (bit_cnt_q != '0) begin
                        fe_d = 1'b1;
                    end
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end else if (sample_edge) begin
                    shift_d = shift_next;
                    if (bit_cnt_q == LastBit) begin
                        bit_cnt_d = '0;
                        wc_d      = wc_q + 16'd1;
                        if (!valid_q || data_ready_in) begin
                            data_out_d = shift_next;
                            valid_d    = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (tmo_fire) begin
                    fe_d      = 1'b1;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            sclk_sync_q <= {SYNC_STAGES{CpolBit}};
            cs_sync_q   <= '1;
            data_sync_q <= '0;
            state_q     <= StIdle;
            sclk_prev_q <= CpolBit;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
            fe_q        <= 1'b0;
            wc_q        <= '0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            data_sync_q <= data_sync_d;
            state_q     <= state_d;
            sclk_prev_q <= sclk_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
            fe_q        <= fe_d;
            wc_q        <= wc_d;
        end
    end

    assign data_out       = data_out_q;
    assign data_valid_out = valid_q;
    assign overrun_out    = ovr_q;
    assign frame_err_out  = fe_q;
    assign word_count_out = wc_q;

endmodule

// File: tb/tb_spi_receive_multi.sv
// Scoreboard bench for spi_receive_multi: dut0 is mode 0, one line, MSB-first,
// TIMEOUT_CYCLES=16; dut1 is mode 3, two lines, LSB-first.
module tb_spi_receive_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut0 signals
    logic        rst0_n, sclk0, cs0_n, ready0;
    logic [0:0]  d0;
    logic [7:0]  dout0;
    logic        vld0, ovr0, fe0;
    logic [15:0] wc0;

    // dut1 signals
    logic        rst1_n, sclk1, cs1_n, ready1;
    logic [1:0]  d1;
    logic [15:0] dout1;
    logic        vld1, ovr1, fe1;
    logic [15:0] wc1;

    int n_checks = 0;
    int n_fail   = 0;
    int ovr0_cnt = 0, fe0_cnt = 0, ovr1_cnt = 0, fe1_cnt = 0;
    logic [7:0]  q0[$];
    logic [15:0] q1[$];

    spi_receive_multi #(
        .DATA_WIDTH(8), .LINES(1), .CPOL(0), .CPHA(0), .MSB_FIRST(1),
        .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)
    ) dut0 (
        .clk_in(clk), .rst_n_in(rst0_n), .chip_data_in(d0), .chip_clk_in(sclk0),
        .chip_sel_in(cs0_n), .data_out(dout0), .data_valid_out(vld0),
        .data_ready_in(ready0), .overrun_out(ovr0), .frame_err_out(fe0),
        .word_count_out(wc0)
    );

    spi_receive_multi #(
        .DATA_WIDTH(8), .LINES(2), .CPOL(1), .CPHA(1), .MSB_FIRST(0),
        .SYNC_STAGES(2), .TIMEOUT_CYCLES(1024)
    ) dut1 (
        .clk_in(clk), .rst_n_in(rst1_n), .chip_data_in(d1), .chip_clk_in(sclk1),
        .chip_sel_in(cs1_n), .data_out(dout1), .data_valid_out(vld1),
        .data_ready_in(ready1), .overrun_out(ovr1), .frame_err_out(fe1),
        .word_count_out(wc1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each accepted word and counts pulses
    always @(negedge clk) begin
        logic [7:0]  e0;
        logic [15:0] e1;
        if (ovr0 === 1'b1) ovr0_cnt++;
        if (fe0 === 1'b1) fe0_cnt++;
        if (ovr1 === 1'b1) ovr1_cnt++;
        if (fe1 === 1'b1) fe1_cnt++;
        if (vld0 === 1'b1 && ready0 === 1'b1) begin
            if (q0.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut0_unexpected_word: got 0x%0h, expected none", dout0);
            end else begin
                e0 = q0.pop_front();
                check("dut0_word", {24'd0, dout0}, {24'd0, e0});
            end
        end
        if (vld1 === 1'b1 && ready1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut1_unexpected_word: got 0x%0h, expected none", dout1);
            end else begin
                e1 = q1.pop_front();
                check("dut1_word", {16'd0, dout1}, {16'd0, e1});
            end
        end
    end

    // Mode 0, MSB-first: data set while DCLK low, sampled on rise
    task automatic spi0_bits(input logic [7:0] v, input int n);
        logic [7:0] b;
        b = v;
        for (int i = 0; i < n; i++) begin
            d0[0] = b[7-i];
            #40 sclk0 = 1'b1;
            #40 sclk0 = 1'b0;
        end
    endtask

    // Mode 3, LSB-first, two lines: data launched on fall, sampled on rise
    task automatic spi1_byte(input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            sclk1 = 1'b0;
            d1    = {b[i], a[i]};
            #40 sclk1 = 1'b1;
            #40;
        end
    endtask

    task automatic drive_sync();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst0_n = 1'b0; cs0_n = 1'b1; sclk0 = 1'b0; d0 = '0; ready0 = 1'b1;
        rst1_n = 1'b0; cs1_n = 1'b1; sclk1 = 1'b1; d1 = '0; ready1 = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_dout0", {24'd0, dout0}, 32'd0);
        check("rst_vld0", {31'd0, vld0}, 32'd0);
        check("rst_ovr0", {31'd0, ovr0}, 32'd0);
        check("rst_fe0", {31'd0, fe0}, 32'd0);
        check("rst_wc0", {16'd0, wc0}, 32'd0);
        check("rst_dout1", {16'd0, dout1}, 32'd0);
        check("rst_vld1", {31'd0, vld1}, 32'd0);
        check("rst_wc1", {16'd0, wc1}, 32'd0);
        drive_sync();
        rst0_n = 1'b1;
        repeat (5) @(posedge clk);

        // Single byte, ready high
        drive_sync();
        q0.push_back(8'hA5);
        cs0_n = 1'b0; #40;
        spi0_bits(8'hA5, 8);
        #40;
        check("wc_after_a5", {16'd0, wc0}, 32'd1);
        cs0_n = 1'b1; #80;

        // Overrun: two words with ready low
        drive_sync();
        ready0 = 1'b0;
        q0.push_back(8'h11);
        cs0_n = 1'b0; #40;
        spi0_bits(8'h11, 8);
        spi0_bits(8'h22, 8);
        #40;
        @(negedge clk);
        check("ovr_dout_held", {24'd0, dout0}, 32'h11);
        check("ovr_vld_held", {31'd0, vld0}, 32'd1);
        check("ovr_pulses", ovr0_cnt, 32'd1);
        check("ovr_wc", {16'd0, wc0}, 32'd2);
        cs0_n = 1'b1; #80;
        drive_sync();
        ready0 = 1'b1;
        repeat (4) @(posedge clk);

        // Partial frame of 5 bits, then a clean byte
        drive_sync();
        cs0_n = 1'b0; #40;
        spi0_bits(8'hF8, 5);
        #40 cs0_n = 1'b1; #80;
        check("fe_partial", fe0_cnt, 32'd1);
        q0.push_back(8'h7E);
        cs0_n = 1'b0; #40;
        spi0_bits(8'h7E, 8);
        #40 cs0_n = 1'b1; #80;

        // DCLK stall after 3 bits (101), then 8 bits of 0xC3
`ifdef SPI_RX_TIMEOUT_EN
        q0.push_back(8'hC3);
`else
        q0.push_back(8'hB8);
`endif
        drive_sync();
        cs0_n = 1'b0; #40;
        spi0_bits(8'hA0, 3);
        repeat (20) @(posedge clk);
        #2;
        spi0_bits(8'hC3, 8);
        #40;
`ifdef SPI_RX_TIMEOUT_EN
        check("tmo_fe_before_cs", fe0_cnt, 32'd2);
`else
        check("tmo_fe_before_cs", fe0_cnt, 32'd1);
`endif
        cs0_n = 1'b1; #80;
        check("tmo_fe_after_cs", fe0_cnt, 32'd2);

        // Reset in the middle of a word
        drive_sync();
        cs0_n = 1'b0; #40;
        spi0_bits(8'hF0, 4);
        drive_sync();
        rst0_n = 1'b0;
        cs0_n  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_dout0", {24'd0, dout0}, 32'd0);
        check("midrst_vld0", {31'd0, vld0}, 32'd0);
        check("midrst_wc0", {16'd0, wc0}, 32'd0);
        check("midrst_ovr0", {31'd0, ovr0}, 32'd0);
        check("midrst_fe0", {31'd0, fe0}, 32'd0);
        drive_sync();
        rst0_n = 1'b1;
        repeat (10) @(posedge clk);
        check("midrst_no_fe", fe0_cnt, 32'd2);

        // dut1: two lines, mode 3, LSB-first
        drive_sync();
        rst1_n = 1'b1;
        repeat (5) @(posedge clk);
        drive_sync();
        q1.push_back({8'h81, 8'h3C});
        cs1_n = 1'b0; #40;
        spi1_byte(8'h3C, 8'h81);
        #40 cs1_n = 1'b1; #80;
        check("dut1_wc", {16'd0, wc1}, 32'd1);
        check("dut1_no_fe", fe1_cnt, 32'd0);
        check("dut1_no_ovr", ovr1_cnt, 32'd0);

        repeat (10) @(posedge clk);
        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);
        check("dut0_ovr_total", ovr0_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
